intr_vec: RTL and testbench

- Parametrised, vectored successor to the fixed three-source interrupt controller on the IO bus.
- Takes NSRC peripheral interrupt lines (uart, spi, gpio, timers, ...) and synchronises each one.
- Per source: level or rising-edge capture, polarity select, enable mask, claim/complete in-service tracking.
- Drives the single CPU `interrupt` line; sits at the same IO decode slot with the same 16-bit register port.

---
 rtl/intr_vec.sv | 202 ++++++++++++++++++++
 tb/tb_intr_vec.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/intr_vec.sv
// Vectored interrupt controller: NSRC synchronised sources with level/edge capture,
// polarity, enable masks and claim/complete tracking. Optional priority/threshold: INTR_PRIO_EN.
module intr_vec #(
  parameter int NSRC = 8,
  parameter int RV   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  output logic            interrupt,
  input  logic [3:0]      io_addr,
  input  logic            io_write,
  input  logic            io_read,
  input  logic [RV-1:0]   io_wdata,
  output logic [RV-1:0]   io_rdata
);

  localparam logic [3:0] A_PEND     = 4'd0;
  localparam logic [3:0] A_ENABLE   = 4'd1;
  localparam logic [3:0] A_MODE     = 4'd2;
  localparam logic [3:0] A_POL      = 4'd3;
  localparam logic [3:0] A_CLAIM    = 4'd4;
  localparam logic [3:0] A_COMPLETE = 4'd5;
  localparam logic [3:0] A_GEN      = 4'd6;
  localparam logic [3:0] A_INSVC    = 4'd10;

  logic [NSRC-1:0] sync1_q, sync1_d;
  logic [NSRC-1:0] sync2_q, sync2_d;
  logic [NSRC-1:0] prev_q, prev_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] enable_q, enable_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] pol_q, pol_d;
  logic [NSRC-1:0] insvc_q, insvc_d;
  logic            gen_q, gen_d;
  logic            interrupt_q, interrupt_d;

  logic [NSRC-1:0] lvl;
  logic [NSRC-1:0] pend_vis;
  logic [NSRC-1:0] qual;
  logic [NSRC-1:0] cand;
  logic [1:0]      prio_v [NSRC];
  logic [1:0]      best_prio;
  logic            win_valid;
  logic [3:0]      win_id;
  logic            claim_fire;
  logic [NSRC-1:0] claim_mask;
  logic [NSRC-1:0] w1c_mask;
  logic            complete_ok;
  logic            unused_wdata;

`ifdef INTR_PRIO_EN
  localparam logic [3:0]  A_THRESH = 4'd7;
  localparam logic [3:0]  A_PRIO0  = 4'd8;
  localparam logic [3:0]  A_PRIO1  = 4'd9;
  localparam logic [31:0] PRIO_MASK = 32'((64'd1 << (2 * NSRC)) - 64'd1);

  logic [31:0] prio_q, prio_d;
  logic [1:0]  thresh_q, thresh_d;

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      prio_v[i] = prio_q[2*i +: 2];
      qual[i]   = (prio_q[2*i +: 2] > thresh_q);
    end
  end
`else
  // All priorities equal: the winner search below degenerates to lowest index.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      prio_v[i] = 2'd0;
    end
    qual = '1;
  end
`endif

  assign unused_wdata = ^io_wdata;

  // Level sources read the live synchronised level; edge sources read the latched bit.
  assign lvl      = sync2_q ^ pol_q;
  assign pend_vis = (mode_q & pend_q) | (~mode_q & lvl);
  assign cand     = pend_vis & enable_q & ~insvc_q & qual;

  // Scanning downward with >= lets ties settle on the lowest index.
  always_comb begin
    win_valid = 1'b0;
    win_id    = 4'd0;
    best_prio = 2'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i] && (!win_valid || prio_v[i] >= best_prio)) begin
        win_valid = 1'b1;
        win_id    = 4'(i);
        best_prio = prio_v[i];
      end
    end
  end

  assign claim_fire  = io_read && (io_addr == A_CLAIM) && win_valid;
  assign claim_mask  = claim_fire ? (NSRC'(1) << win_id) : '0;
  assign w1c_mask    = (io_write && io_addr == A_PEND) ? io_wdata[NSRC-1:0] : '0;
  assign complete_ok = io_write && (io_addr == A_COMPLETE) && (int'(io_wdata[3:0]) < NSRC);

  always_comb begin
    sync1_d     = src;
    sync2_d     = sync1_q;
    prev_d      = lvl;
    enable_d    = enable_q;
    mode_d      = mode_q;
    pol_d       = pol_q;
    gen_d       = gen_q;
    insvc_d     = insvc_q;
    // A new rising edge outranks any clear in the same cycle.
    pend_d      = mode_q & ((lvl & ~prev_q) | (pend_q & ~(w1c_mask | claim_mask)));
    interrupt_d = gen_q & (|cand);
    if (io_write) begin
      case (io_addr)
        A_ENABLE: enable_d = io_wdata[NSRC-1:0];
        A_MODE:   mode_d   = io_wdata[NSRC-1:0];
        A_POL:    pol_d    = io_wdata[NSRC-1:0];
        A_GEN:    gen_d    = io_wdata[0];
        default:  ;
      endcase
    end
    if (complete_ok) begin
      insvc_d = insvc_d & ~(NSRC'(1) << io_wdata[3:0]);
    end
    insvc_d = insvc_d | claim_mask;
  end

`ifdef INTR_PRIO_EN
  always_comb begin
    prio_d   = prio_q;
    thresh_d = thresh_q;
    if (io_write) begin
      case (io_addr)
        A_THRESH: thresh_d      = io_wdata[1:0];
        A_PRIO0:  prio_d[15:0]  = io_wdata[15:0] & PRIO_MASK[15:0];
        A_PRIO1:  prio_d[31:16] = io_wdata[15:0] & PRIO_MASK[31:16];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q   <= '0;
      thresh_q <= '0;
    end else begin
      prio_q   <= prio_d;
      thresh_q <= thresh_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      pend_q      <= '0;
      enable_q    <= '0;
      mode_q      <= '0;
      pol_q       <= '0;
      insvc_q     <= '0;
      gen_q       <= 1'b0;
      interrupt_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      pend_q      <= pend_d;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      pol_q       <= pol_d;
      insvc_q     <= insvc_d;
      gen_q       <= gen_d;
      interrupt_q <= interrupt_d;
    end
  end

  assign interrupt = interrupt_q;

  always_comb begin
    io_rdata = '0;
    case (io_addr)
      A_PEND:   io_rdata[NSRC-1:0] = pend_vis;
      A_ENABLE: io_rdata[NSRC-1:0] = enable_q;
      A_MODE:   io_rdata[NSRC-1:0] = mode_q;
      A_POL:    io_rdata[NSRC-1:0] = pol_q;
      A_CLAIM:  io_rdata = win_valid ? {1'b1, 11'b0, win_id} : '0;
      A_GEN:    io_rdata[0] = gen_q;
      A_INSVC:  io_rdata[NSRC-1:0] = insvc_q;
`ifdef INTR_PRIO_EN
      A_THRESH: io_rdata[1:0] = thresh_q;
      A_PRIO0:  io_rdata = prio_q[15:0];
      A_PRIO1:  io_rdata = prio_q[31:16];
`endif
      default:  io_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_intr_vec.sv
// Directed bench for intr_vec (NSRC=8); the priority section follows INTR_PRIO_EN.
module tb_intr_vec;

  logic        clk;
  logic        reset;
  logic [7:0]  src;
  logic        interrupt;
  logic [3:0]  io_addr;
  logic        io_write;
  logic        io_read;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;

  int checks = 0;
  int errors = 0;

  intr_vec #(.NSRC(8), .RV(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .src       (src),
    .interrupt (interrupt),
    .io_addr   (io_addr),
    .io_write  (io_write),
    .io_read   (io_read),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] addr, input logic [15:0] data);
    io_addr  = addr;
    io_wdata = data;
    io_write = 1'b1;
    tick();
    io_write = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [3:0] addr, input logic [15:0] exp);
    io_addr = addr;
    #1;
    chk(tag, io_rdata, exp);
  endtask

  task automatic claim(input string tag, input logic [15:0] exp);
    io_addr = 4'd4;
    io_read = 1'b1;
    #1;
    chk(tag, io_rdata, exp);
    tick();
    io_read = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {15'b0, interrupt}, {15'b0, exp});
  endtask

  initial begin
    reset = 1'b1; src = '0; io_addr = '0; io_write = 1'b0; io_read = 1'b0; io_wdata = '0;
    tick(); tick(); tick();
    reset = 1'b0;

    // Reset state
    for (int a = 0; a < 16; a++) rd($sformatf("rst_rd%0d", a), 4'(a), 16'h0000);
    chk_irq("rst_irq", 1'b0);
    src = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_irq("dis_irq", 1'b0);
    end
    rd("lvl_pend_ff", 4'd0, 16'h00FF);
    src = 8'h00;
    tick(); tick();
    rd("lvl_pend_drop", 4'd0, 16'h0000);

    // Edge capture on src[2] and latency
    wr(4'd2, 16'h0004);
    wr(4'd1, 16'h0004);
    wr(4'd6, 16'h0001);
    src = 8'h04;
    tick();
    src = 8'h00;
    tick();
    rd("edge_pend_e2", 4'd0, 16'h0000);
    tick();
    rd("edge_pend_e3", 4'd0, 16'h0004);
    chk_irq("edge_irq_e3", 1'b0);
    tick();
    chk_irq("edge_irq_e4", 1'b1);
    claim("edge_claim", 16'h8002);
    rd("edge_pend_after", 4'd0, 16'h0000);
    rd("edge_insvc", 4'd10, 16'h0004);
    tick();
    chk_irq("edge_irq_low", 1'b0);
    wr(4'd5, 16'h0009);
    rd("complete_oob", 4'd10, 16'h0004);
    wr(4'd5, 16'h0002);
    rd("complete_ok", 4'd10, 16'h0000);

    // Level, active-low src[5]
    wr(4'd2, 16'h0000);
    wr(4'd1, 16'h0020);
    wr(4'd3, 16'h0020);
    rd("lvl_pend", 4'd0, 16'h0020);
    tick();
    chk_irq("lvl_irq", 1'b1);
    claim("lvl_claim", 16'h8005);
    rd("lvl_pend_kept", 4'd0, 16'h0020);
    rd("lvl_insvc", 4'd10, 16'h0020);
    src = 8'h20;
    tick();
    rd("lvl_pend_1cyc", 4'd0, 16'h0020);
    tick();
    rd("lvl_pend_2cyc", 4'd0, 16'h0000);
    wr(4'd5, 16'h0005);
    rd("lvl_complete", 4'd10, 16'h0000);
    tick(); tick();
    chk_irq("lvl_irq_off", 1'b0);

    // Two simultaneous edges, lowest index first
    src = 8'h00;
    tick(); tick();
    wr(4'd3, 16'h0000);
    wr(4'd1, 16'h0042);
    wr(4'd2, 16'h0042);
    src = 8'h42;
    tick();
    src = 8'h00;
    tick(); tick();
    rd("dual_pend", 4'd0, 16'h0042);
    claim("dual_claim1", 16'h8001);
    claim("dual_claim6", 16'h8006);
    claim("dual_claim_none", 16'h0000);
    rd("dual_insvc", 4'd10, 16'h0042);
    wr(4'd5, 16'h0001);
    wr(4'd5, 16'h0006);
    rd("dual_insvc_clr", 4'd10, 16'h0000);

    // W1C, and an edge colliding with a W1C on src[3] (disabled)
    wr(4'd2, 16'h0008);
    src = 8'h08;
    tick();
    src = 8'h00;
    tick(); tick();
    rd("w1c_pend_set", 4'd0, 16'h0008);
    wr(4'd0, 16'h0008);
    rd("w1c_clear", 4'd0, 16'h0000);
    src = 8'h08;
    tick();
    src = 8'h00;
    tick();
    wr(4'd0, 16'h0008);
    rd("w1c_vs_edge", 4'd0, 16'h0008);
    tick();
    chk_irq("disabled_irq", 1'b0);
    wr(4'd1, 16'h0008);
    tick();
    chk_irq("enabled_fire", 1'b1);

    // Reset asserted together with a claim read
    io_addr = 4'd4;
    io_read = 1'b1;
    reset   = 1'b1;
    tick();
    reset   = 1'b0;
    io_read = 1'b0;
    chk_irq("rst2_irq", 1'b0);
    for (int a = 0; a < 16; a++) rd($sformatf("rst2_rd%0d", a), 4'(a), 16'h0000);

`ifdef INTR_PRIO_EN
    wr(4'd2, 16'h0042);
    wr(4'd1, 16'h0042);
    wr(4'd6, 16'h0001);
    wr(4'd8, 16'h3008);
    wr(4'd7, 16'h0002);
    rd("prio0_rd", 4'd8, 16'h3008);
    rd("thresh_rd", 4'd7, 16'h0002);
    src = 8'h42;
    tick();
    src = 8'h00;
    tick(); tick();
    rd("prio_pend", 4'd0, 16'h0042);
    claim("prio_claim6", 16'h8006);
    wr(4'd5, 16'h0006);
    claim("prio_claim_none", 16'h0000);
    tick();
    chk_irq("prio_irq_thresh", 1'b0);
`else
    wr(4'd7, 16'h0003);
    wr(4'd8, 16'hFFFF);
    wr(4'd9, 16'hFFFF);
    rd("noprio_rd7", 4'd7, 16'h0000);
    rd("noprio_rd8", 4'd8, 16'h0000);
    rd("noprio_rd9", 4'd9, 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
